// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier: operand and product widths,
// the controller state encoding and the registered output bundle.
package mult_pkg;

    localparam int MULT_WIDTH  = 4;
    localparam int MULT_PROD_W = MULT_WIDTH * 2 + 1;
    localparam int MULT_CW     = $clog2(MULT_WIDTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        TEST = 3'd2,
        ADDS = 3'd3,
        SHFT = 3'd4,
        DONE = 3'd5
    } mult_state_t;

    // Controller outputs that are a pure function of the state register.
    typedef struct packed {
        logic load;
        logic add;
        logic shift;
        logic busy;
        logic done;
    } mult_out_t;

    localparam mult_out_t MULT_OUT_OFF = 5'b00000;

    // Map a state onto its output strobes; unknown encodings drive nothing.
    function automatic mult_out_t decode_outs(input mult_state_t st);
        mult_out_t o;
        o = MULT_OUT_OFF;
        case (st)
            LOAD:    begin o.load  = 1'b1; o.busy = 1'b1; end
            TEST:    begin o.busy  = 1'b1; end
            ADDS:    begin o.add   = 1'b1; o.busy = 1'b1; end
            SHFT:    begin o.shift = 1'b1; o.busy = 1'b1; end
            DONE:    begin o.done  = 1'b1; end
            default: begin o = MULT_OUT_OFF; end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mult_ctrl_if.sv
// Handshake and datapath-strobe bundle between the multiplier controller
// (slave side) and the system/datapath that drives it (master side).
interface mult_ctrl_if import mult_pkg::*; #(
    parameter int CW = MULT_CW
) ();
    logic          start;
    logic          ack;
    logic          m_lsb;
    logic          load;
    logic          ADD;
    logic          SHIFT;
    logic          busy;
    logic          done;
    logic [CW-1:0] iter;

    modport master (
        output start, ack, m_lsb,
        input  load, ADD, SHIFT, busy, done, iter
    );

    modport slave (
        input  start, ack, m_lsb,
        output load, ADD, SHIFT, busy, done, iter
    );
endinterface

// File: rtl/mult_ctrl.sv
// Shift-add multiplier sequencer: one TEST/(ADD)/SHIFT round per multiplier
// bit, then holds done until the consumer acknowledges. Every output comes
// straight from a flop so nothing on the bus is combinationally tied to inputs.
module mult_ctrl import mult_pkg::*; #(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    mult_ctrl_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    mult_state_t   state_r;
    mult_state_t   next_state_s;
    mult_out_t     outs_r;
    logic [CW-1:0] iter_r;
    logic          iter_last_s;

    assign iter_last_s = (iter_r == CW'(WIDTH - 1));

    // Next-state selection; LSB is only consulted in TEST, after the
    // datapath has had a full cycle to settle from the previous shift.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: next_state_s = TEST;
            TEST: begin
                if (bus.m_lsb) begin
                    next_state_s = ADDS;
                end else begin
                    next_state_s = SHFT;
                end
            end
            ADDS: next_state_s = SHFT;
            SHFT: begin
                if (iter_last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = TEST;
                end
            end
            DONE: begin
                if (bus.ack && bus.start) begin
                    next_state_s = LOAD;
                end else if (bus.ack) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State, iteration counter and output registers; outputs are decoded
    // from the state being entered so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            iter_r  <= {CW{1'b0}};
            outs_r  <= MULT_OUT_OFF;
        end else begin
            state_r <= next_state_s;
            outs_r  <= decode_outs(next_state_s);
            case (state_r)
                LOAD: iter_r <= {CW{1'b0}};
                SHFT: begin
                    if (iter_last_s) begin
                        iter_r <= iter_r;
                    end else begin
                        iter_r <= iter_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: iter_r <= iter_r;
            endcase
        end
    end

    assign bus.load  = outs_r.load;
    assign bus.ADD   = outs_r.add;
    assign bus.SHIFT = outs_r.shift;
    assign bus.busy  = outs_r.busy;
    assign bus.done  = outs_r.done;
    assign bus.iter  = iter_r;

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: a behavioural shift-add datapath feeds m_lsb back,
// a table of operand pairs drives the main function, and hand-written
// sequences cover handshake corners and asynchronous reset mid-operation.
module tb_mult_ctrl;
    import mult_pkg::*;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [8:0] prod;
        int         lat;
        int         adds;
        int         hold;
        logic       chain;
        int         pulse;
    } vec_t;

    logic clk;
    logic reset;
    logic [3:0] mplier_r;
    logic [3:0] mcand_r;
    logic [8:0] prod_r;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int viol     = 0;
    logic add_q, shift_q, load_q;

    vec_t vec [7];
    vec_t sb [$];

    mult_ctrl_if #(.CW(2)) bus ();

    mult_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath: load {0,multiplier}, add into the top bits, shift right.
    always @(posedge clk) begin
        if (reset)
            prod_r <= 9'd0;
        else if (bus.load)
            prod_r <= {5'd0, mplier_r};
        else if (bus.ADD)
            prod_r[8:4] <= {1'b0, prod_r[7:4]} + {1'b0, mcand_r};
        else if (bus.SHIFT)
            prod_r <= prod_r >> 1;
    end

    assign bus.m_lsb = prod_r[0];

    // Strobe invariant monitor: exclusivity and single-cycle width.
    always @(negedge clk) begin
        if (reset) begin
            add_q   <= 1'b0;
            shift_q <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            if ((bus.ADD && bus.SHIFT) || (bus.load && (bus.ADD || bus.SHIFT)) ||
                (bus.busy && bus.done) || (add_q && bus.ADD) ||
                (shift_q && bus.SHIFT) || (load_q && bus.load))
                viol <= viol + 1;
            add_q   <= bus.ADD;
            shift_q <= bus.SHIFT;
            load_q  <= bus.load;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Issue one multiply (optionally together with ack from DONE) and score it.
    task automatic run_op(input int idx, input vec_t v, input logic with_ack);
        vec_t e;
        int adds, shifts, loads, lat;
        logic got;
        logic [3:0] mask;
        mplier_r  = v.a;
        mcand_r   = v.b;
        bus.start = 1'b1;
        bus.ack   = with_ack;
        sb.push_back(v);
        @(negedge clk);
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        chk($sformatf("load_pulse[%0d]", idx), bus.load, 1);
        chk($sformatf("busy_load[%0d]", idx), bus.busy, 1);
        chk($sformatf("done_low[%0d]", idx), bus.done, 0);
        adds = 0; shifts = 0; loads = 0; lat = 0; got = 1'b0; mask = 4'd0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.ADD) begin
                adds++;
                mask[bus.iter] = 1'b1;
            end
            if (bus.SHIFT) shifts++;
            if (bus.load) loads++;
            if (bus.done) begin
                got = 1'b1;
                lat = n;
                break;
            end
            bus.start = (n == v.pulse);
            bus.ack   = (n == v.pulse);
        end
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        chk($sformatf("done_seen[%0d]", idx), got, 1);
        e = sb.pop_front();
        chk($sformatf("latency[%0d]", idx), lat, e.lat);
        chk($sformatf("product[%0d]", idx), prod_r, e.prod);
        chk($sformatf("add_count[%0d]", idx), adds, e.adds);
        chk($sformatf("shift_count[%0d]", idx), shifts, 4);
        chk($sformatf("add_iters[%0d]", idx), mask, e.a);
        chk($sformatf("extra_load[%0d]", idx), loads, 0);
        chk($sformatf("iter_final[%0d]", idx), bus.iter, 3);
        chk($sformatf("busy_done[%0d]", idx), bus.busy, 0);
    endtask

    // Hold done for a while, then acknowledge and confirm a quiet IDLE.
    task automatic ack_release(input int idx, input int hold);
        logic bad;
        bad = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            if (!bus.done || bus.ADD || bus.SHIFT || bus.load || bus.busy) bad = 1'b1;
        end
        chk($sformatf("done_hold[%0d]", idx), bad, 0);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        chk($sformatf("ack_idle[%0d]", idx), {bus.done, bus.busy, bus.load}, 0);
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.load || bus.done || bus.busy) bad = 1'b1;
        end
        chk($sformatf("idle_quiet[%0d]", idx), bad, 0);
    endtask

    initial begin
        vec_t rec;
        int adds;
        logic got;
        //          a      b      prod     lat adds hold chain pulse
        vec[0] = '{4'd0,  4'd7,  9'd0,    9,  0,   0,   1'b0, 0};
        vec[1] = '{4'd15, 4'd15, 9'd225,  13, 4,   0,   1'b0, 3};
        vec[2] = '{4'd10, 4'd3,  9'd30,   11, 2,   5,   1'b0, 0};
        vec[3] = '{4'd5,  4'd9,  9'd45,   11, 2,   0,   1'b1, 0};
        vec[4] = '{4'd1,  4'd1,  9'd1,    10, 1,   0,   1'b1, 0};
        vec[5] = '{4'd8,  4'd15, 9'd120,  10, 1,   2,   1'b0, 0};
        vec[6] = '{4'd3,  4'd6,  9'd18,   11, 2,   0,   1'b0, 0};

        reset = 1'b1; bus.start = 1'b0; bus.ack = 1'b0;
        mplier_r = 4'd0; mcand_r = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {bus.load, bus.ADD, bus.SHIFT, bus.busy, bus.done, bus.iter}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {bus.load, bus.busy, bus.done}, 0);

        for (int i = 0; i < 7; i++) begin
            run_op(i, vec[i], (i > 0) && vec[i-1].chain);
            if (!vec[i].chain) ack_release(i, vec[i].hold);
        end

        // Asynchronous reset during the second ADDS cycle of an all-ones run.
        mplier_r = 4'd15; mcand_r = 4'd15;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        adds = 0; got = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.ADD) adds++;
            if (bus.ADD && adds == 2) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_reach_add2", got, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_outs", {bus.load, bus.ADD, bus.SHIFT, bus.busy, bus.done, bus.iter}, 0);
        @(negedge clk);
        chk("rst_held_outs", {bus.load, bus.ADD, bus.SHIFT, bus.busy, bus.done}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_release_idle", {bus.load, bus.busy, bus.done}, 0);
        rec = '{4'd15, 4'd15, 9'd225, 13, 4, 0, 1'b0, 0};
        run_op(7, rec, 1'b0);
        ack_release(7, 0);

        chk("strobe_invariants", viol, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mult_ctrl.md
Name: mult_ctrl

Overview:
- FSM controller that sequences the shift-add multiplier datapath register by issuing one-hot ADD/SHIFT strobes, one pair per multiplier bit.
- Sits between the system start/ack handshake and the 9-bit product register.
- Samples the register LSB to decide add-then-shift versus shift-only, counts WIDTH iterations, then holds done until acknowledged.

Parameters:
- WIDTH, 4, multiplier/multiplicand width in bits; number of iterations; legal range >= 2.
- CW, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a multiply; sampled in IDLE, or in DONE together with ack.
- ack  in  1  consumer has taken the product; sampled only in DONE.
- m_lsb  in  1  bit 0 of the datapath product register.
- load  out  1  one-cycle pulse: datapath loads {0, multiplier} into the product register.
- ADD  out  1  datapath writes {carry, sum} into product[8:4] this edge.
- SHIFT  out  1  datapath shifts the product register right by one this edge.
- busy  out  1  high from LOAD through the last SHIFT inclusive.
- done  out  1  product valid; level, held until ack.
- iter  out  CW  current iteration index (0..WIDTH-1), for debug/visibility.

Behaviour:
- States: IDLE, LOAD, TEST, ADDS, SHFT, DONE. All outputs are decoded from the registered state; there are no combinational input-to-output paths.
- Reset (asynchronous, any time, including mid-operation):
  - state goes to IDLE and iter to 0.
  - load, ADD, SHIFT, busy and done go to 0 immediately.
  - No partial product is reported.
- Transitions:
  - IDLE: start=1 -> LOAD; else stay.
  - LOAD: load=1, iter<=0 -> TEST.
  - TEST: decision cycle, no strobes. Samples m_lsb: 1 -> ADDS; 0 -> SHFT.
  - ADDS: ADD=1 -> SHFT.
  - SHFT: SHIFT=1. If iter==WIDTH-1 -> DONE; else iter<=iter+1 and -> TEST.
  - DONE: done=1, busy=0.
    - ack=1 and start=1: -> LOAD (back-to-back operation).
    - ack=1 only: -> IDLE.
    - Otherwise stay.
- Output invariants:
  - ADD and SHIFT are never high in the same cycle.
  - load never coincides with ADD or SHIFT.
  - Each strobe is at most one cycle wide.
- Busy-period rules:
  - start is ignored while busy=1; no queuing.
  - ack outside DONE is ignored.
- m_lsb is sampled only in TEST, one cycle after the previous SHIFT edge. This gives the datapath a full cycle to settle.
- Latency, counting edges after the edge that samples start:
  - done rises at edge 1 + 2*WIDTH + P, where P = popcount(multiplier).
  - WIDTH=4: 9 edges for a zero multiplier, 13 edges for all ones.
- Wrap-around: iter never exceeds WIDTH-1; it wraps to 0 only via LOAD.
- Illegal or unreached state encodings recover to IDLE.

Decomposition:
- Shared package mult_pkg:
  - state enum typedef mult_state_t.
  - constant MULT_WIDTH=4, shared by the datapath and the controller.
  - product width constant MULT_WIDTH*2+1.
- Single module with the iteration counter inline. No sub-module is warranted.

Test Plan:
- Reset mid-operation: start, then assert reset during the 2nd ADDS cycle -> all outputs 0 in the same cycle, state IDLE; a new start after release -> normal sequence from LOAD.
- Multiplier 4'b0000 with a behavioural datapath model: start -> strobe trace load,(SHIFT)x4 with no ADD; done at edge 9; product 0.
- Multiplier 4'b1111, multiplicand 4'b1111: start -> 4 ADD and 4 SHIFT strobes, alternating; done at edge 13; product 9'd225; ADD&SHIFT never high together.
- Multiplier 4'b1010, multiplicand 4'b0011: ADD only on iterations 1 and 3; done at edge 11; product 30. Hold ack=0 for 5 cycles -> done stays 1 and no strobes are issued.
- Handshake edges:
  - start pulsed while busy -> ignored; exactly one done.
  - ack and start in the same DONE cycle -> next state LOAD; done drops; second product correct.
  - ack with no start -> IDLE; busy=0.
